// File: rtl/edge_width_pkg.sv
// Shared types and constants for the edge width meter.
package edge_width_pkg;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] width;
    logic             sat;
  } width_rec_t;

endpackage

// File: rtl/edge_width_meter_if.sv
// Record output channel: valid/ready handshake plus the {level, width, sat} payload.
interface edge_width_meter_if #(
  parameter int unsigned CNT_W = edge_width_pkg::CNT_W
);

  logic             valid_o;
  logic             ready_i;
  logic             level_o;
  logic [CNT_W-1:0] width_o;
  logic             sat_o;

  modport master (
    output valid_o,
    output level_o,
    output width_o,
    output sat_o,
    input  ready_i
  );

  modport slave (
    input  valid_o,
    input  level_o,
    input  width_o,
    input  sat_o,
    output ready_i
  );

endinterface

// File: rtl/edge_width_meter_sat_counter.sv
// Phase-length counter: loads 1, counts up, sticks at all-ones and latches sat.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;
  logic         r_sat;

  // sat only sets when an increment is refused, so a phase of exactly MAX is not flagged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (load) begin
      r_cnt <= W'(1);
      r_sat <= 1'b0;
    end else if (inc) begin
      if (r_cnt == MAX) begin
        r_sat <= 1'b1;
      end else begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule

// File: rtl/edge_width_meter.sv
// Turns edge-detector pulses into one {level, width, sat} record per completed phase,
// offered through a one-entry holding register with sticky overrun/protocol flags.
module edge_width_meter #(
  parameter int unsigned CNT_W = edge_width_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rising_edge_i,
  input  logic               falling_edge_i,
  edge_width_meter_if.master rec,
  output logic               overrun_o,
  output logic               proto_err_o
);

  import edge_width_pkg::*;

  state_t           r_state;
  logic             r_valid;
  logic             r_level;
  logic [CNT_W-1:0] r_width;
  logic             r_sat;
  logic             r_overrun;
  logic             r_proto_err;

  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_sat;
  logic             w_both;
  logic             w_any;
  logic             w_in_high;
  logic             w_in_low;
  logic             w_emit;
  logic             w_load;
  logic             w_inc;
  logic             w_proto;

  assign w_both    = rising_edge_i & falling_edge_i;
  assign w_any     = rising_edge_i | falling_edge_i;
  assign w_in_high = (r_state == HIGH);
  assign w_in_low  = (r_state == LOW);

  // A phase completes only on the opposite edge; a repeated edge is a fault
  assign w_emit  = !w_both && ((w_in_high && falling_edge_i) || (w_in_low && rising_edge_i));
  assign w_proto = w_both || (w_in_high && rising_edge_i) || (w_in_low && falling_edge_i);
  assign w_load  = w_any && !w_both;
  assign w_inc   = !w_any && (r_state != IDLE);

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .inc   (w_inc),
    .cnt   (w_cnt),
    .sat   (w_cnt_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_level     <= 1'b0;
      r_width     <= '0;
      r_sat       <= 1'b0;
      r_overrun   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_both) begin
        r_state <= IDLE;
      end else if (rising_edge_i) begin
        r_state <= HIGH;
      end else if (falling_edge_i) begin
        r_state <= LOW;
      end

      if (w_proto) begin
        r_proto_err <= 1'b1;
      end

      // A record arriving while the held one is stalled is dropped, never overwrites
      if (w_emit) begin
        if (!r_valid || rec.ready_i) begin
          r_valid <= 1'b1;
          r_level <= w_in_high;
          r_width <= w_cnt;
          r_sat   <= w_cnt_sat;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rec.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rec.valid_o  = r_valid;
  assign rec.level_o  = r_level;
  assign rec.width_o  = r_width;
  assign rec.sat_o    = r_sat;
  assign overrun_o    = r_overrun;
  assign proto_err_o  = r_proto_err;

endmodule

// File: doc/edge_width_meter.md
# edge_width_meter

Measures the duration, in clock cycles, of each high and low phase of a signal from the single-cycle `rising_edge`/`falling_edge` pulses of the edge detector stage. It sits directly downstream of that detector. Each completed phase becomes one record `{level, width, sat}`, offered on a valid/ready output with a one-entry holding register. Protocol faults and dropped records are flagged.

## Interface
- `CNT_W`, 8: width of the phase counter and of `width_o`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rising_edge_i`  in  1  single-cycle pulse, from the edge detector.
- `falling_edge_i`  in  1  single-cycle pulse, from the edge detector.
- `ready_i`  in  1  consumer accepts a record this cycle.
- `valid_o`  out  1  record held and offered.
- `level_o`  out  1  phase level of the record: 1 = high phase, 0 = low phase.
- `width_o`  out  CNT_W  phase length in cycles.
- `sat_o`  out  1  the width saturated at 2^CNT_W-1.
- `overrun_o`  out  1  sticky; a completed record was dropped.
- `proto_err_o`  out  1  sticky; an illegal edge sequence was seen.

## Operation
- FSM states: IDLE, HIGH, LOW. State after reset is IDLE.
- IDLE:
  - rising → HIGH, counter loads 1.
  - falling → LOW, counter loads 1.
  - No record is emitted; the first phase is partial.
- HIGH:
  - falling → emit `{1, cnt, sat}`, go to LOW, counter loads 1.
  - rising → set `proto_err_o`, restart the counter at 1, stay in HIGH, no record.
- LOW: mirror of HIGH. rising → emit `{0, cnt, sat}`, go to HIGH. falling → protocol error.
- Both pulses in the same cycle, any state: set `proto_err_o`, go to IDLE, no record.
- No edge in HIGH/LOW: counter increments and saturates at 2^CNT_W-1. The `sat` bit latches for the current phase and is cleared on each load.
- Holding register, on a record-emit cycle:
  - If `!valid_o`, or `valid_o && ready_i`: load the new record, `valid_o`=1.
  - If `valid_o && !ready_i`: drop the new record and set `overrun_o`. The held record is unchanged.
- Holding register, with no emit: `valid_o && ready_i` clears `valid_o`.
- While `valid_o && !ready_i`, `level_o`/`width_o`/`sat_o` are stable.
- `overrun_o` and `proto_err_o` clear only on reset.

## Timing
- Reset values:
  - `valid_o`=0, `level_o`=0, `width_o`=0, `sat_o`=0, `overrun_o`=0, `proto_err_o`=0.
  - FSM = IDLE, counter = 0.
- Reset is asynchronous assert and synchronous-release-safe. Asserting it mid-phase discards the phase and any held record.
- Width definition: a start edge pulse in cycle t and an end edge pulse in cycle t+k give width k. The counter equals k in cycle t+k.
- Latency: `valid_o` rises in cycle t+k+1, registered.
- Minimum width is 1: edges in consecutive cycles.
- Throughput is one record per cycle when `ready_i` is held high.
- `ready_i` has no combinational path to any output. Outputs are all registered.

## Structure
- Package `edge_width_pkg`:
  - `state_t` enum {IDLE, HIGH, LOW}.
  - `width_rec_t` struct {level, width[CNT_W-1:0], sat}, parameterised through a localparam default.
  - `CNT_MAX` constant.
- Sub-module `sat_counter`: parameter `W`, inputs `load`/`inc`, outputs `cnt` and `sat`. Load value is 1.
- The top level holds the FSM, the holding register and the sticky flags.

## Test plan
- Reset, then rising at cycle 10 and falling at cycle 15, `ready_i`=1 → `valid_o`=1 in cycle 16 with level 1, width 5, sat 0. No record for the initial IDLE phase.
- Rising/falling alternating every cycle for 8 cycles, `ready_i`=1 → one record per cycle, width 1, level alternating 1,0,...
- `CNT_W`=4, high phase of 20 cycles → width 15, sat 1. The next phase starts with sat 0.
- `ready_i`=0, two phases complete → first record held stable, second dropped, `overrun_o`=1. Raise `ready_i` → `valid_o` falls next cycle. `overrun_o` stays 1.
- Two rising pulses without a falling → `proto_err_o`=1, no record. Simultaneous rising+falling → FSM to IDLE, next edge emits nothing.
- Assert `reset` mid-phase with `valid_o`=1 → all outputs 0 immediately. After release, the first edge emits nothing.
